alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_imm_sext.sv | 15 +
 rtl/alu_core.sv | 92 +++++++++
 tb/tb_alu_core.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU core: opcodes, operand-B select values and
// default data path widths.
package alu_pkg;

  localparam int DEF_WIDTH     = 18;
  localparam int DEF_IMM_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_NAND = 2'b10,
    OP_NOR  = 2'b11
  } alu_op_e;

  localparam logic SEL_REG = 1'b0;
  localparam logic SEL_IMM = 1'b1;

endpackage

// File: rtl/alu_imm_sext.sv
// Sign-extends a two's-complement immediate to the full data path width.
module alu_imm_sext
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic [IMM_WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0]     imm_ext_o
);

  // Replicate the immediate sign bit into the upper bits.
  assign imm_ext_o = {{(WIDTH-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};

endmodule

// File: rtl/alu_core.sv
// Single-cycle ALU (ADD/AND/NAND/NOR) with registered result and flags.
// Operand B is either the register operand or the sign-extended immediate.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     SRC1,
  input  logic [WIDTH-1:0]     SRC2,
  input  logic [IMM_WIDTH-1:0] IMM,
  input  logic                 mux1_select,
  input  logic [1:0]           mux2_select,
  output logic [WIDTH-1:0]     Output,
  output logic                 out_valid,
  output logic                 zero,
  output logic                 negative,
  output logic                 carry,
  output logic                 overflow
);

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_q, negative_q, out_valid_q;

  alu_imm_sext #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_imm_sext (
    .imm_i     (IMM),
    .imm_ext_o (imm_ext)
  );

  assign op_b = (mux1_select == SEL_IMM) ? imm_ext : SRC2;
  assign sum  = {1'b0, SRC1} + {1'b0, op_b};

  // Operation decode; carry/overflow only meaningful for ADD.
  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (alu_op_e'(mux2_select))
      OP_ADD: begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (SRC1[WIDTH-1] == op_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != SRC1[WIDTH-1]);
      end
      OP_AND:  result_d = SRC1 & op_b;
      OP_NAND: result_d = ~(SRC1 & op_b);
      OP_NOR:  result_d = ~(SRC1 | op_b);
      default: result_d = '0;
    endcase
  end

  // Result/flag registers: reset wins, load on in_valid, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        zero_q     <= (result_d == '0);
        negative_q <= result_d[WIDTH-1];
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign Output    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed, table-driven bench for alu_core with hand-computed expectations.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W  = 18;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  SRC1, SRC2;
  logic [IW-1:0] IMM;
  logic          mux1_select;
  logic [1:0]    mux2_select;
  logic [W-1:0]  Output;
  logic          out_valid, zero, negative, carry, overflow;

  int errors = 0;
  int checks = 0;

  alu_core #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .SRC1        (SRC1),
    .SRC2        (SRC2),
    .IMM         (IMM),
    .mux1_select (mux1_select),
    .mux2_select (mux2_select),
    .Output      (Output),
    .out_valid   (out_valid),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic [IW-1:0] imm;
    logic          m1;
    logic [1:0]    m2;
    logic [W-1:0]  exp_out;
    logic          exp_z;
    logic          exp_n;
    logic          exp_c;
    logic          exp_v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge load, sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic valid);
    @(negedge clk);
    in_valid    = valid;
    SRC1        = v.src1;
    SRC2        = v.src2;
    IMM         = v.imm;
    mux1_select = v.m1;
    mux2_select = v.m2;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, ".out"},  32'(Output),   32'(v.exp_out));
    check({v.name, ".z"},    32'(zero),     32'(v.exp_z));
    check({v.name, ".n"},    32'(negative), 32'(v.exp_n));
    check({v.name, ".c"},    32'(carry),    32'(v.exp_c));
    check({v.name, ".v"},    32'(overflow), 32'(v.exp_v));
    check({v.name, ".vld"},  32'(out_valid), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] held_out;

    //            name        src1      src2      imm    m1  m2     out       z  n  c  v
    vecs.push_back('{"add_reg",  18'h01234, 18'h05678, 6'h00, 1'b0, 2'b00, 18'h068AC, 0, 0, 0, 0});
    vecs.push_back('{"and",      18'h0FFFF, 18'h000FF, 6'h00, 1'b0, 2'b01, 18'h000FF, 0, 0, 0, 0});
    vecs.push_back('{"nand",     18'h0ABCD, 18'h0EF01, 6'h00, 1'b0, 2'b10, 18'h354FE, 0, 1, 0, 0});
    vecs.push_back('{"nor",      18'h01111, 18'h00000, 6'h00, 1'b0, 2'b11, 18'h3EEEE, 0, 1, 0, 0});
    vecs.push_back('{"sext_neg", 18'h00000, 18'h12345, 6'h2A, 1'b1, 2'b00, 18'h3FFEA, 0, 1, 0, 0});
    vecs.push_back('{"wrap_imm", 18'h07FFF, 18'h00000, 6'h3F, 1'b1, 2'b00, 18'h07FFE, 0, 0, 1, 0});
    vecs.push_back('{"ovf_pos",  18'h1FFFF, 18'h00001, 6'h00, 1'b0, 2'b00, 18'h20000, 0, 1, 0, 1});
    vecs.push_back('{"add_zero", 18'h3FFFF, 18'h00001, 6'h00, 1'b0, 2'b00, 18'h00000, 1, 0, 1, 0});
    vecs.push_back('{"ovf_neg",  18'h20000, 18'h20000, 6'h00, 1'b0, 2'b00, 18'h00000, 1, 0, 1, 1});
    vecs.push_back('{"and_clr",  18'h3FFFF, 18'h3FFFF, 6'h00, 1'b0, 2'b01, 18'h3FFFF, 0, 1, 0, 0});
    vecs.push_back('{"nor_zero", 18'h3FFFF, 18'h00000, 6'h00, 1'b0, 2'b11, 18'h00000, 1, 0, 0, 0});
    vecs.push_back('{"sext_pos", 18'h00010, 18'h3FFFF, 6'h1F, 1'b1, 2'b00, 18'h0002F, 0, 0, 0, 0});
    vecs.push_back('{"and_imm",  18'h2AAAA, 18'h00000, 6'h35, 1'b1, 2'b01, 18'h2AAA0, 0, 1, 0, 0});

    rst_n = 1'b0; in_valid = 1'b0; SRC1 = '0; SRC2 = '0; IMM = '0;
    mux1_select = 1'b0; mux2_select = 2'b00;
    repeat (2) @(posedge clk);

    // Reset state
    #1;
    check("rst.out", 32'(Output), 32'd0);
    check("rst.z",   32'(zero), 32'd1);
    check("rst.vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back-to-back
    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1);
      step();
      check_vec(vecs[i]);
    end

    // Hold: in_valid low for 3 cycles keeps result and flags, drops out_valid
    held_out = Output;
    v = vecs[0];
    v.src1 = 18'h11111; v.src2 = 18'h22222;
    for (int k = 0; k < 3; k++) begin
      drive(v, 1'b0);
      step();
      check("hold.out", 32'(Output), 32'(held_out));
      check("hold.z",   32'(zero), 32'd0);
      check("hold.n",   32'(negative), 32'd1);
      check("hold.vld", 32'(out_valid), 32'd0);
    end

    // Load a carry/overflow result, then reset with in_valid high
    drive(vecs[8], 1'b1);
    step();
    check_vec(vecs[8]);
    drive(vecs[0], 1'b1);
    rst_n = 1'b0;
    step();
    check("rstv.out", 32'(Output), 32'd0);
    check("rstv.z",   32'(zero), 32'd1);
    check("rstv.n",   32'(negative), 32'd0);
    check("rstv.c",   32'(carry), 32'd0);
    check("rstv.v",   32'(overflow), 32'd0);
    check("rstv.vld", 32'(out_valid), 32'd0);

    // After release, idle for 3 cycles: reset values held
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post.out", 32'(Output), 32'd0);
      check("post.z",   32'(zero), 32'd1);
      check("post.vld", 32'(out_valid), 32'd0);
    end

    // First operation after reset goes through normally
    drive(vecs[2], 1'b1);
    step();
    check_vec(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
